// File: rtl/ps2_mouse_packet_ctrl_if.sv
// PS/2 pins plus decoded mouse packet fields for ps2_mouse_packet_ctrl.
// master: the controller (samples pins, drives fields); slave: pin driver and field consumer.
interface ps2_mouse_packet_ctrl_if;
    logic       mouse_clk;
    logic       mouse_data;
    logic       packet_valid;
    logic       frame_error;
    logic [2:0] buttons;
    logic [7:0] x_move;
    logic       x_sign;
    logic       y_sign;
    logic       y_overflow;
    logic [7:0] paddle_dir;
    logic [1:0] paddle_speed;

    modport master (
        input  mouse_clk, mouse_data,
        output packet_valid, frame_error, buttons, x_move, x_sign, y_sign,
               y_overflow, paddle_dir, paddle_speed
    );

    modport slave (
        output mouse_clk, mouse_data,
        input  packet_valid, frame_error, buttons, x_move, x_sign, y_sign,
               y_overflow, paddle_dir, paddle_speed
    );
endinterface

// File: rtl/ps2_mouse_packet_ctrl.sv
// PS/2 mouse receiver: pin conditioning, 11-bit framing, 3-byte packet assembly and paddle speed.
// Optional macro PS2_TIMEOUT_EN adds an idle counter that aborts partial frames and packets.
module ps2_mouse_packet_ctrl #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                    clock_100Mhz,
    input  logic                    reset,
    ps2_mouse_packet_ctrl_if.master bus
);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} bit_state_t;
    typedef enum logic [1:0] {P_BYTE0, P_BYTE1, P_BYTE2} pkt_idx_t;
    typedef struct packed {
        logic       y_ovf;
        logic       y_sign;
        logic       x_sign;
        logic [2:0] buttons;
    } hdr_t;

    localparam int FCW = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] r_clk_sync, r_data_sync;
    logic                   w_clk_s, w_data_s;
    logic                   r_filt_clk, r_fall;
    logic [FCW-1:0]         r_filt_cnt;

    bit_state_t r_bit_state, w_bit_next;
    pkt_idx_t   r_pkt_idx, w_pkt_next;
    logic [7:0] r_shift;
    logic [2:0] r_bit_cnt;
    logic       r_parity;
    logic       w_start, w_shift_en, w_par_en, w_byte_done, w_byte_good, w_byte_bad;
    logic       w_store0, w_store1, w_commit, w_error, w_timeout;

    hdr_t       r_hdr, r_out_hdr;
    logic [7:0] r_byte1, r_x_move, r_paddle_dir;
    logic [1:0] r_paddle_speed, w_speed;
    logic       r_packet_valid, r_frame_error;
    logic [8:0] w_dy, w_mag;

    assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
    assign w_data_s = r_data_sync[SYNC_STAGES-1];

    // The filtered clock flips only after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clock_100Mhz) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
            r_filt_clk  <= 1'b1;
            r_filt_cnt  <= '0;
            r_fall      <= 1'b0;
        end else begin
            r_clk_sync  <= (r_clk_sync << 1) | SYNC_STAGES'(bus.mouse_clk);
            r_data_sync <= (r_data_sync << 1) | SYNC_STAGES'(bus.mouse_data);
            r_fall      <= 1'b0;
            if (w_clk_s == r_filt_clk) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FCW'(FILTER_LEN - 1)) begin
                r_filt_clk <= w_clk_s;
                r_filt_cnt <= '0;
                r_fall     <= ~w_clk_s;
            end else begin
                r_filt_cnt <= r_filt_cnt + FCW'(1);
            end
        end
    end

    always_ff @(posedge clock_100Mhz) begin
        if (reset) r_bit_state <= S_IDLE;
        else       r_bit_state <= w_bit_next;
    end

    always_comb begin
        // NOTE: default first so no latch is inferred on untaken paths.
        w_bit_next = r_bit_state;
        if (w_timeout) begin
            w_bit_next = S_IDLE;
        end else if (r_fall) begin
            case (r_bit_state)
                S_IDLE:   if (!w_data_s) w_bit_next = S_DATA;
                S_DATA:   if (r_bit_cnt == 3'd7) w_bit_next = S_PARITY;
                S_PARITY: w_bit_next = S_STOP;
                default:  w_bit_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_start     = 1'b0;
        w_shift_en  = 1'b0;
        w_par_en    = 1'b0;
        w_byte_done = 1'b0;
        if (r_fall) begin
            case (r_bit_state)
                S_IDLE:   w_start     = ~w_data_s;
                S_DATA:   w_shift_en  = 1'b1;
                S_PARITY: w_par_en    = 1'b1;
                default:  w_byte_done = 1'b1;
            endcase
        end
    end

    // Odd parity: data bits plus parity bit XOR to 1.
    assign w_byte_good = w_byte_done & w_data_s & (^{r_shift, r_parity});
    assign w_byte_bad  = w_byte_done & ~w_byte_good;

    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_parity  <= 1'b0;
        end else begin
            if (w_start) r_bit_cnt <= '0;
            if (w_shift_en) begin
                r_shift   <= {w_data_s, r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_par_en) r_parity <= w_data_s;
        end
    end

    always_ff @(posedge clock_100Mhz) begin
        if (reset) r_pkt_idx <= P_BYTE0;
        else       r_pkt_idx <= w_pkt_next;
    end

    always_comb begin
        w_pkt_next = r_pkt_idx;
        if (w_byte_bad || w_timeout) begin
            w_pkt_next = P_BYTE0;
        end else if (w_byte_good) begin
            case (r_pkt_idx)
                P_BYTE0: if (r_shift[3]) w_pkt_next = P_BYTE1;
                P_BYTE1: w_pkt_next = P_BYTE2;
                default: w_pkt_next = P_BYTE0;
            endcase
        end
    end

    always_comb begin
        w_store0 = w_byte_good && (r_pkt_idx == P_BYTE0) && r_shift[3];
        w_store1 = w_byte_good && (r_pkt_idx == P_BYTE1);
        w_commit = w_byte_good && (r_pkt_idx == P_BYTE2);
        w_error  = w_byte_bad || w_timeout;
    end

`ifdef PS2_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TCW-1:0] r_to_cnt;
    logic           w_busy;

    assign w_busy    = (r_bit_state != S_IDLE) || (r_pkt_idx != P_BYTE0);
    assign w_timeout = w_busy && !r_fall && (r_to_cnt == TCW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock_100Mhz) begin
        if (reset || r_fall || !w_busy || w_timeout) r_to_cnt <= '0;
        else                                         r_to_cnt <= r_to_cnt + TCW'(1);
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Byte 2 is still in the shift register during the commit cycle.
    assign w_dy  = {r_hdr.y_sign, r_shift};
    assign w_mag = w_dy[8] ? (~w_dy + 9'd1) : w_dy;

    always_comb begin
        if (r_hdr.y_ovf || (w_mag >= 9'd32)) w_speed = 2'd3;
        else if (w_mag >= 9'd8)              w_speed = 2'd2;
        else if (w_mag != 9'd0)              w_speed = 2'd1;
        else                                 w_speed = 2'd0;
    end

    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            r_hdr          <= '0;
            r_byte1        <= '0;
            r_out_hdr      <= '0;
            r_x_move       <= '0;
            r_paddle_dir   <= '0;
            r_paddle_speed <= '0;
            r_packet_valid <= 1'b0;
            r_frame_error  <= 1'b0;
        end else begin
            r_packet_valid <= w_commit;
            r_frame_error  <= w_error;
            if (w_store0) r_hdr <= {r_shift[7], r_shift[5:4], r_shift[2:0]};
            if (w_store1) r_byte1 <= r_shift;
            if (w_commit) begin
                r_out_hdr      <= r_hdr;
                r_x_move       <= r_byte1;
                r_paddle_dir   <= r_shift;
                r_paddle_speed <= w_speed;
            end
        end
    end

    assign bus.packet_valid = r_packet_valid;
    assign bus.frame_error  = r_frame_error;
    assign bus.buttons      = r_out_hdr.buttons;
    assign bus.x_sign       = r_out_hdr.x_sign;
    assign bus.y_sign       = r_out_hdr.y_sign;
    assign bus.y_overflow   = r_out_hdr.y_ovf;
    assign bus.x_move       = r_x_move;
    assign bus.paddle_dir   = r_paddle_dir;
    assign bus.paddle_speed = r_paddle_speed;

endmodule

// File: tb/tb_ps2_mouse_packet_ctrl.sv
// Scoreboard bench for ps2_mouse_packet_ctrl: directed PS/2 byte streams, expected pulses queued,
// a monitor pops and compares every packet_valid / frame_error pulse.
module tb_ps2_mouse_packet_ctrl;

    localparam int HALF       = 25;
    localparam int TB_TIMEOUT = 3000;

    typedef struct {
        bit         is_err;
        logic [2:0] buttons;
        logic [7:0] x_move;
        logic       x_sign;
        logic       y_sign;
        logic       y_ovf;
        logic [7:0] dir;
        logic [1:0] speed;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_compared   = 0;
    int   n_mismatched = 0;
    exp_t sb[$];
    exp_t held;

    always #5 clk = ~clk;

    ps2_mouse_packet_ctrl_if ps2_if ();

    ps2_mouse_packet_ctrl #(
        .SYNC_STAGES   (2),
        .FILTER_LEN    (8),
        .TIMEOUT_CYCLES(TB_TIMEOUT)
    ) dut (
        .clock_100Mhz(clk),
        .reset       (reset),
        .bus         (ps2_if)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_packet_valid"}, 32'(ps2_if.packet_valid), 0);
        check({tag, "_frame_error"},  32'(ps2_if.frame_error),  0);
        check({tag, "_buttons"},      32'(ps2_if.buttons),      0);
        check({tag, "_x_move"},       32'(ps2_if.x_move),       0);
        check({tag, "_x_sign"},       32'(ps2_if.x_sign),       0);
        check({tag, "_y_sign"},       32'(ps2_if.y_sign),       0);
        check({tag, "_y_overflow"},   32'(ps2_if.y_overflow),   0);
        check({tag, "_paddle_dir"},   32'(ps2_if.paddle_dir),   0);
        check({tag, "_paddle_speed"}, 32'(ps2_if.paddle_speed), 0);
    endtask

    task automatic exp_pkt(input logic [2:0] b, input logic [7:0] x, input logic xs,
                           input logic ys, input logic yo, input logic [7:0] d,
                           input logic [1:0] s);
        held.is_err  = 1'b0;
        held.buttons = b;
        held.x_move  = x;
        held.x_sign  = xs;
        held.y_sign  = ys;
        held.y_ovf   = yo;
        held.dir     = d;
        held.speed   = s;
        sb.push_back(held);
    endtask

    task automatic exp_err();
        exp_t e;
        e        = held;
        e.is_err = 1'b1;
        sb.push_back(e);
    endtask

    task automatic send_bit(input logic v, input bit glitch);
        ps2_if.mouse_data = v;
        if (glitch) begin
            repeat (12) @(negedge clk);
            ps2_if.mouse_clk = 1'b0;
            repeat (3) @(negedge clk);
            ps2_if.mouse_clk = 1'b1;
            repeat (HALF - 15) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
        ps2_if.mouse_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_if.mouse_clk = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par = 1'b0,
                             input int glitch_bit = -1);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i], i == glitch_bit);
        send_bit(bad_par ? (^b) : (~^b), 1'b0);
        send_bit(1'b1, 1'b0);
        ps2_if.mouse_data = 1'b1;
        repeat (100) @(negedge clk);
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, 32'(sb.size()), 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && (ps2_if.packet_valid || ps2_if.frame_error)) begin
                if (sb.size() == 0) begin
                    check("unexpected_pulse", 32'(ps2_if.packet_valid || ps2_if.frame_error), 0);
                end else begin
                    e = sb.pop_front();
                    check("packet_valid", 32'(ps2_if.packet_valid), 32'(!e.is_err));
                    check("frame_error",  32'(ps2_if.frame_error),  32'(e.is_err));
                    check("buttons",      32'(ps2_if.buttons),      32'(e.buttons));
                    check("x_move",       32'(ps2_if.x_move),       32'(e.x_move));
                    check("x_sign",       32'(ps2_if.x_sign),       32'(e.x_sign));
                    check("y_sign",       32'(ps2_if.y_sign),       32'(e.y_sign));
                    check("y_overflow",   32'(ps2_if.y_overflow),   32'(e.y_ovf));
                    check("paddle_dir",   32'(ps2_if.paddle_dir),   32'(e.dir));
                    check("paddle_speed", 32'(ps2_if.paddle_speed), 32'(e.speed));
                end
            end
        end
    end

    initial begin : stimulus
        ps2_if.mouse_clk  = 1'b1;
        ps2_if.mouse_data = 1'b1;
        held = '{default: '0};
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_outputs_zero("after_reset");
        repeat (10000) @(negedge clk);
        check_outputs_zero("idle_10k");

        // Small negative dy, positive dy at the 32 boundary, overflow flags.
        exp_pkt(3'b000, 8'h00, 1'b0, 1'b1, 1'b0, 8'hFB, 2'd1);
        send_pkt(8'h28, 8'h00, 8'hFB);
        exp_pkt(3'b000, 8'h10, 1'b0, 1'b0, 1'b0, 8'h20, 2'd3);
        send_pkt(8'h08, 8'h10, 8'h20);
        exp_pkt(3'b000, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 2'd3);
        send_pkt(8'h88, 8'h00, 8'h00);
        exp_pkt(3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0);
        send_pkt(8'h48, 8'h00, 8'h00);
        drain("basic");

        // Speed class boundaries: -32, -31, +8, -256.
        exp_pkt(3'b111, 8'h55, 1'b1, 1'b1, 1'b0, 8'hE0, 2'd3);
        send_pkt(8'h3F, 8'h55, 8'hE0);
        exp_pkt(3'b000, 8'hAA, 1'b0, 1'b1, 1'b0, 8'hE1, 2'd2);
        send_pkt(8'h28, 8'hAA, 8'hE1);
        exp_pkt(3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h08, 2'd2);
        send_pkt(8'h08, 8'h00, 8'h08);
        exp_pkt(3'b000, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 2'd3);
        send_pkt(8'h28, 8'h00, 8'h00);
        drain("speed");

        // Bad parity on byte 1 aborts the packet; fields hold until the next good one.
        exp_err();
        send_byte(8'h08);
        send_byte(8'h10, 1'b1);
        exp_pkt(3'b001, 8'h00, 1'b0, 1'b0, 1'b0, 8'h05, 2'd1);
        send_pkt(8'h09, 8'h00, 8'h05);
        drain("parity");

        // Stray byte without bit 3 is dropped; a short clock glitch adds no bit.
        send_byte(8'h00);
        exp_pkt(3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h0A, 2'd2);
        send_byte(8'h08);
        send_byte(8'h00);
        send_byte(8'h0A, 1'b0, 3);
        drain("resync_glitch");

        // Lone header byte followed by a long idle.
`ifdef PS2_TIMEOUT_EN
        exp_err();
        send_byte(8'h08);
        repeat (TB_TIMEOUT + 10) @(negedge clk);
        exp_pkt(3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h01, 2'd1);
        send_pkt(8'h08, 8'h00, 8'h01);
`else
        send_byte(8'h08);
        repeat (TB_TIMEOUT + 10) @(negedge clk);
        exp_pkt(3'b000, 8'h08, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0);
        send_pkt(8'h08, 8'h00, 8'h01);
`endif
        drain("timeout");

        // Reset in the middle of a frame: no pulse, outputs cleared, next packet clean.
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        held = '{default: '0};
        @(negedge clk);
        check_outputs_zero("mid_frame_reset");
        exp_pkt(3'b010, 8'h01, 1'b0, 1'b0, 1'b0, 8'h07, 2'd1);
        send_pkt(8'h0A, 8'h01, 8'h07);

        repeat (200) @(negedge clk);
        drain("final");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
